// File: rtl/data_path_pkg.sv
// ----------------------------------------------------------------------------
// data_path_pkg: instruction field layout, funct codes and ALU-op decode.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package data_path_pkg;

   localparam int c_INSTR_W  = 32;
   localparam int c_REG_AW   = 5;

   localparam int c_OP_MSB    = 31;
   localparam int c_OP_LSB    = 26;
   localparam int c_RS_MSB    = 25;
   localparam int c_RS_LSB    = 21;
   localparam int c_RT_MSB    = 20;
   localparam int c_RT_LSB    = 16;
   localparam int c_RD_MSB    = 15;
   localparam int c_RD_LSB    = 11;
   localparam int c_SHAMT_MSB = 10;
   localparam int c_SHAMT_LSB = 6;
   localparam int c_FUNCT_MSB = 5;
   localparam int c_FUNCT_LSB = 0;

   localparam logic [5:0] OP_RTYPE = 6'b000000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;

   typedef enum logic [3:0] {
      ALU_NOP = 4'd0,
      ALU_ADD = 4'd1,
      ALU_SUB = 4'd2,
      ALU_AND = 4'd3,
      ALU_OR  = 4'd4,
      ALU_XOR = 4'd5,
      ALU_NOR = 4'd6,
      ALU_SLT = 4'd7,
      ALU_SLL = 4'd8
   } alu_op_t;

   // Anything that is not one of the eight supported R-type ops maps to ALU_NOP.
   function automatic alu_op_t decode_funct(input logic [5:0] op, input logic [5:0] funct);
      alu_op_t v_op;
      v_op = ALU_NOP;
      if (op == OP_RTYPE) begin
         case (funct)
            FN_ADD:  v_op = ALU_ADD;
            FN_SUB:  v_op = ALU_SUB;
            FN_AND:  v_op = ALU_AND;
            FN_OR:   v_op = ALU_OR;
            FN_XOR:  v_op = ALU_XOR;
            FN_NOR:  v_op = ALU_NOR;
            FN_SLT:  v_op = ALU_SLT;
            FN_SLL:  v_op = ALU_SLL;
            default: v_op = ALU_NOP;
         endcase
      end
      return v_op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/data_path_if.sv
// ----------------------------------------------------------------------------
// data_path_if: instruction in / ALU result out.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface data_path_if #(
   parameter int DATA_W = 32
);
   logic [31:0]       instruction;
   logic [DATA_W-1:0] DS;

   modport master (output instruction, input DS);
   modport slave  (input instruction, output DS);
endinterface

`default_nettype wire

// File: rtl/data_path_register_bank.sv
// ----------------------------------------------------------------------------
// register_bank: 2 async read ports, 1 sync write port, resets to reg[i] = i.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module register_bank
   import data_path_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32
) (
   input  wire logic                CLK,
   input  wire logic                RST,
   input  wire logic [c_REG_AW-1:0] i_rd_addr_a,
   input  wire logic [c_REG_AW-1:0] i_rd_addr_b,
   output      logic [DATA_W-1:0]   o_rd_data_a,
   output      logic [DATA_W-1:0]   o_rd_data_b,
   input  wire logic                i_wr_en,
   input  wire logic [c_REG_AW-1:0] i_wr_addr,
   input  wire logic [DATA_W-1:0]   i_wr_data
);

   logic [DATA_W-1:0] r_regs [NREGS];

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= DATA_W'(i);
         end
      end else if (i_wr_en && (i_wr_addr != '0)) begin
         r_regs[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_regs[i_rd_addr_a];
   assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_regs[i_rd_addr_b];

endmodule

`default_nettype wire

// File: rtl/data_path.sv
// ----------------------------------------------------------------------------
// data_path: single-cycle R-type decode, register read, ALU and write-back.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module data_path
   import data_path_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32
) (
   input  wire logic  CLK,
   input  wire logic  RST,
   data_path_if.slave bus
);

   logic [5:0]          w_op;
   logic [c_REG_AW-1:0] w_rs;
   logic [c_REG_AW-1:0] w_rt;
   logic [c_REG_AW-1:0] w_rd;
   logic [4:0]          w_shamt;
   logic [5:0]          w_funct;
   alu_op_t             w_alu_op;
   logic                w_valid;
   logic [DATA_W-1:0]   w_a;
   logic [DATA_W-1:0]   w_b;
   logic [DATA_W-1:0]   w_result;

   assign w_op     = bus.instruction[c_OP_MSB:c_OP_LSB];
   assign w_rs     = bus.instruction[c_RS_MSB:c_RS_LSB];
   assign w_rt     = bus.instruction[c_RT_MSB:c_RT_LSB];
   assign w_rd     = bus.instruction[c_RD_MSB:c_RD_LSB];
   assign w_shamt  = bus.instruction[c_SHAMT_MSB:c_SHAMT_LSB];
   assign w_funct  = bus.instruction[c_FUNCT_MSB:c_FUNCT_LSB];

   assign w_alu_op = decode_funct(w_op, w_funct);
   assign w_valid  = (w_alu_op != ALU_NOP);

   register_bank #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_register_bank (
      .CLK         (CLK),
      .RST         (RST),
      .i_rd_addr_a (w_rs),
      .i_rd_addr_b (w_rt),
      .o_rd_data_a (w_a),
      .o_rd_data_b (w_b),
      .i_wr_en     (w_valid),
      .i_wr_addr   (w_rd),
      .i_wr_data   (w_result)
   );

   // Invalid instructions fall through to zero, which also suppresses the write.
   always_comb begin
      w_result = '0;
      case (w_alu_op)
         ALU_ADD: w_result = w_a + w_b;
         ALU_SUB: w_result = w_a - w_b;
         ALU_AND: w_result = w_a & w_b;
         ALU_OR:  w_result = w_a | w_b;
         ALU_XOR: w_result = w_a ^ w_b;
         ALU_NOR: w_result = ~(w_a | w_b);
         ALU_SLT: w_result = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
         ALU_SLL: w_result = w_b << w_shamt;
         default: w_result = '0;
      endcase
   end

   assign bus.DS = w_result;

endmodule

`default_nettype wire

// File: tb/tb_data_path.sv
// ----------------------------------------------------------------------------
// tb_data_path: directed plus random R-type stream, reference model and scoreboard.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_data_path;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } sb_entry_t;

   logic CLK;
   logic RST;

   data_path_if #(.DATA_W(32)) bus ();

   data_path #(
      .DATA_W (32),
      .NREGS  (32)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int unsigned model_regs [32];
   sb_entry_t   sb_q [$];
   int          n_tests;
   int          n_failed;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) model_regs[i] = i;
   endfunction

   // Reference semantics straight from the instruction set description.
   function automatic bit ref_exec(input logic [31:0] ins, output int unsigned res);
      int unsigned op, rs, rt, sh, fn, a, b;
      op = ins >> 26;
      rs = (ins >> 21) & 31;
      rt = (ins >> 16) & 31;
      sh = (ins >> 6) & 31;
      fn = ins & 63;
      a  = (rs == 0) ? 0 : model_regs[rs];
      b  = (rt == 0) ? 0 : model_regs[rt];
      res = 0;
      if (op != 0) return 1'b0;
      case (fn)
         32: res = a + b;
         34: res = a - b;
         36: res = a & b;
         37: res = a | b;
         38: res = a ^ b;
         39: res = ~(a | b);
         42: res = (int'(a) < int'(b)) ? 1 : 0;
         0:  res = b << sh;
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   function automatic logic [31:0] probe(input int unsigned r);
      return (r << 21) | 32'h0000_0025;
   endfunction

   // Issue one instruction for one clock: expectation before the edge, model write at the edge.
   task automatic run_cycle(input logic [31:0] ins, input string name, input bit mid_reset = 1'b0);
      int unsigned res;
      bit          ok;
      sb_entry_t   e;
      bus.instruction = ins;
      if (mid_reset) begin
         #1;
         RST = 1'b1;
         model_reset();
      end
      ok = ref_exec(ins, res);
      e.exp  = res;
      e.name = name;
      sb_q.push_back(e);
      @(posedge CLK);
      if (!RST && ok && (((ins >> 11) & 31) != 0)) model_regs[(ins >> 11) & 31] = res;
      #1;
      if (mid_reset) RST = 1'b0;
   endtask

   task automatic run_held(input logic [31:0] ins, input string name);
      run_cycle(ins, {name, "_pre"});
      run_cycle(ins, {name, "_post"});
      run_cycle(32'h0, {name, "_nop"});
   endtask

   task automatic check_reg(input int unsigned r, input string name);
      run_cycle(probe(r), name);
   endtask

   always @(negedge CLK) begin
      sb_entry_t e;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         n_tests++;
         if (bus.DS !== e.exp) begin
            n_failed++;
            $display("FAIL %s: DS=%h expected %h", e.name, bus.DS, e.exp);
         end
      end
   end

   initial begin
      logic [31:0] ins;
      logic [5:0]  fns [8];
      n_tests  = 0;
      n_failed = 0;
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};
      RST = 1'b1;
      bus.instruction = 32'h0;
      model_reset();
      @(posedge CLK);
      #1;
      run_cycle(probe(7), "reset_read_r7");
      RST = 1'b0;
      check_reg(31, "reset_read_r31");

      run_held(32'h01E9A022, "sub_r20");
      check_reg(20, "r20_after_sub");
      run_held(32'h0289A022, "sub_r20_self");
      check_reg(20, "r20_neg3");
      run_held(32'h00AF7820, "add_r15");
      run_held(32'h012F7820, "add_r15_upd");
      run_held(32'h028FA82A, "slt_true");
      check_reg(21, "r21_slt");
      run_held(32'h01F4A82A, "slt_false");
      run_held(32'h018A5824, "and_12_10");
      run_held(32'h018A5825, "or_12_10");
      run_held(32'h018A5826, "xor_12_10");
      run_held(32'h018A5827, "nor_12_10");
      run_held(32'h00035900, "sll_3_4");
      run_held(32'h00211020, "add_r2");
      run_held(32'h00210820, "add_r1_self");
      check_reg(2, "r2_dbl");
      run_held(32'h8C000000, "invalid_op");
      run_held(32'h0289A03F, "invalid_funct");
      check_reg(20, "r20_unchanged");
      run_held(32'h01E90020, "write_r0");
      check_reg(0, "r0_zero");
      run_cycle(32'h01E9A022, "sub_r20_pre_reset");
      run_cycle(probe(20), "mid_reset_r20", 1'b1);
      run_cycle(probe(21), "after_reset_r21");

      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         if ($urandom_range(0, 7) != 0) begin
            ins[31:26] = 6'h00;
            if ($urandom_range(0, 9) != 0) ins[5:0] = fns[$urandom_range(0, 7)];
         end
         run_cycle(ins, "random");
         if ($urandom_range(0, 3) == 0) run_cycle(ins, "random_hold");
      end
      for (int r = 0; r < 32; r++) check_reg(r, "final_reg");

      for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge CLK);
      #1;
      if (sb_q.size() != 0) begin
         n_tests++;
         n_failed++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule

`default_nettype wire
